// File: rtl/demux1_4_if.sv
// demux1_4_if: beat source plus four lane consumers around the 1-to-4 demux.
// The master side drives beats and lane readies; the slave side is the demux.
interface demux1_4_if #(parameter int W = 2);
   logic [W-1:0] i;
   logic [1:0]   s;
   logic         i_valid;
   logic         i_ready;
   logic [W-1:0] o0, o1, o2, o3;
   logic [3:0]   o_valid;
   logic [3:0]   o_ready;
   logic         frame_done;
   modport master (output i, s, i_valid, o_ready, input i_ready, o0, o1, o2, o3, o_valid, frame_done);
   modport slave  (input i, s, i_valid, o_ready, output i_ready, o0, o1, o2, o3, o_valid, frame_done);
endinterface

// File: rtl/demux1_4.sv
// demux1_4: registered 1-to-4 lane demultiplexer with one holding register per lane.
// Define AUTO_SEL_EN to route by an internal round-robin pointer instead of s.
module demux1_4 #(parameter int W = 2) (
   input logic       clk,
   input logic       rst,
   demux1_4_if.slave bus
);
   logic [3:0][W-1:0] data;
   logic [3:0]        vld;
   logic [1:0]        d;
   logic              acc;
`ifdef AUTO_SEL_EN
   logic [1:0] rr;
   logic       fd;
   assign d = rr;
   always_ff @(posedge clk)
      if (rst) begin
         rr <= '0;
         fd <= 1'b0;
      end else begin
         rr <= acc ? rr + 2'd1 : rr;
         fd <= acc && rr == 2'd3;
      end
   assign bus.frame_done = fd;
`else
   assign d = bus.s;
   assign bus.frame_done = 1'b0;
`endif
   // Readiness looks only at the addressed lane, so a stalled lane never blocks others.
   assign bus.i_ready = ~vld[d] | bus.o_ready[d];
   assign acc = bus.i_valid & bus.i_ready;
   always_ff @(posedge clk)
      if (rst) begin
         vld  <= '0;
         data <= '0;
      end else begin
         for (int n = 0; n < 4; n++)
            if (acc && d == 2'(n)) begin
               data[n] <= bus.i;
               vld[n]  <= 1'b1;
            end else if (vld[n] && bus.o_ready[n]) begin
               vld[n] <= 1'b0;
            end
      end
   assign bus.o_valid = vld;
   assign bus.o0 = data[0];
   assign bus.o1 = data[1];
   assign bus.o2 = data[2];
   assign bus.o3 = data[3];
endmodule

// File: tb/tb_demux1_4.sv
// tb_demux1_4: random traffic against per-lane expected-beat queues; a negedge
// monitor checks lane outputs while the stimulus side predicts acceptance.
module tb_demux1_4;
   localparam int W = 2;
   logic clk = 1'b0;
   logic rst;
   logic mon_en = 1'b0;
   logic fd_exp = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   rr_m = 0;
   logic [W-1:0] q[4][$];
   demux1_4_if #(.W(W)) bus ();
   demux1_4 #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [W-1:0] lane(input int n);
      return n == 0 ? bus.o0 : n == 1 ? bus.o1 : n == 2 ? bus.o2 : bus.o3;
   endfunction
   // Monitor: a lane must be valid exactly when a beat is owed to it, showing the oldest one.
   always @(negedge clk)
      if (mon_en) begin
         for (int n = 0; n < 4; n++) begin
            check($sformatf("o_valid[%0d]", n), 32'(bus.o_valid[n]), 32'(q[n].size() != 0));
            if (q[n].size() != 0) begin
               check($sformatf("o%0d", n), 32'(lane(n)), 32'(q[n][0]));
               if (bus.o_ready[n]) void'(q[n].pop_front());
            end
         end
         check("frame_done", 32'(bus.frame_done), 32'(fd_exp));
      end
   initial begin
      int  d;
      logic exp_rdy;
      rst = 1'b1;
      bus.i_valid = 1'b1;
      bus.i = 2'b11;
      bus.s = 2'd1;
      bus.o_ready = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_valid = 1'b0;
      bus.o_ready = 4'b1111;
      @(negedge clk);
      check("reset o_valid", 32'(bus.o_valid), 32'h0);
      for (int n = 0; n < 4; n++) check($sformatf("reset o%0d", n), 32'(lane(n)), 32'h0);
      check("reset i_ready", 32'(bus.i_ready), 32'h1);
      check("reset frame_done", 32'(bus.frame_done), 32'h0);
      #1 mon_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         if (rst) begin
            for (int n = 0; n < 4; n++) q[n].delete();
            rr_m = 0;
         end
         rst = $urandom_range(79) == 0;
         bus.i = W'($urandom);
         bus.s = 2'($urandom);
         bus.i_valid = $urandom_range(3) != 0;
         for (int n = 0; n < 4; n++) bus.o_ready[n] = $urandom_range(9) < 7;
         @(negedge clk);
         #1;
`ifdef AUTO_SEL_EN
         d = rr_m;
`else
         d = int'(bus.s);
`endif
         // The monitor has already retired any beat draining this cycle.
         exp_rdy = q[d].size() == 0;
         check("i_ready", 32'(bus.i_ready), 32'(exp_rdy));
         fd_exp = 1'b0;
         if (!rst && bus.i_valid && exp_rdy) begin
            q[d].push_back(bus.i);
`ifdef AUTO_SEL_EN
            fd_exp = d == 3;
            rr_m = (rr_m + 1) % 4;
`endif
         end
      end
      @(posedge clk);
      #1 mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
